// File: rtl/sample_pacer_if.sv
// Handshake and paced-output bundle for sample_pacer.
// master = filter/sink side, slave = the pacer.
interface sample_pacer_if #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned DEPTH_LOG = 3
);
  logic                 req_in;
  logic                 ack_in;
  logic [0:DWIDTH-1]    data_in;
  logic [0:DWIDTH-1]    sample_out;
  logic                 sample_valid;
  logic                 underflow;
  logic [DEPTH_LOG:0]   level;

  modport master (
    output req_in, data_in,
    input  ack_in, sample_out, sample_valid, underflow, level
  );

  modport slave (
    input  req_in, data_in,
    output ack_in, sample_out, sample_valid, underflow, level
  );
endinterface

// File: rtl/sample_pacer.sv
// Buffers bursty filter output in a FIFO and replays one sample every DIV clocks.
// Optional PACER_UNDERFLOW_ZERO_EN: emit zero-valued strobes on underflow and while refilling.
module sample_pacer #(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DEPTH_LOG   = 3,
  parameter int unsigned START_LEVEL = 4,
  parameter int unsigned DIV         = 8,
  parameter int unsigned DIV_LOG     = 4
) (
  input  logic           clk,
  input  logic           rst,
  sample_pacer_if.slave  bus
);

  localparam logic [DEPTH_LOG:0]  LvlFull  = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]  LvlStart = (DEPTH_LOG+1)'(START_LEVEL);
  localparam logic [DIV_LOG-1:0]  TickMax  = DIV_LOG'(DIV - 1);

  typedef enum logic {StFill, StRun} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_ack;
  logic [DEPTH_LOG-1:0]  r_wptr;
  logic [DEPTH_LOG-1:0]  r_rptr;
  logic [DEPTH_LOG:0]    r_level;
  logic [DIV_LOG-1:0]    r_cnt;
  logic [0:DWIDTH-1]     r_sample;
  logic                  r_valid;
  logic                  r_underflow;
  logic [0:DWIDTH-1]     r_mem [DEPTH];

  logic                  w_tick;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_uf;
  logic                  w_ack_next;
  logic [DEPTH_LOG:0]    w_level_next;

  assign w_tick     = (r_cnt == TickMax);
  assign w_wr       = bus.req_in && r_ack;
  // Pop decision uses the pre-edge level, so a same-edge write into empty is not poppable.
  assign w_pop      = (r_state == StRun) && w_tick && (r_level != '0);
  assign w_uf       = (r_state == StRun) && w_tick && (r_level == '0);
  assign w_ack_next = bus.req_in && !r_ack && (r_level < LvlFull);

  always_comb begin
    w_level_next = r_level;
    unique case ({w_wr, w_pop})
      2'b10:   w_level_next = r_level + (DEPTH_LOG+1)'(1);
      2'b01:   w_level_next = r_level - (DEPTH_LOG+1)'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFill: if (w_level_next >= LvlStart) w_state_next = StRun;
      StRun:  if (w_uf) w_state_next = StFill;
      default: w_state_next = StFill;
    endcase
  end

`ifdef PACER_UNDERFLOW_ZERO_EN
  logic w_emit_zero;
  // Sticky underflow distinguishes a refill after starvation from the initial fill.
  assign w_emit_zero = w_uf || ((r_state == StFill) && w_tick && r_underflow);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StFill;
      r_ack       <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_cnt       <= '0;
      r_sample    <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack_next;
      r_level <= w_level_next;
      r_cnt   <= w_tick ? '0 : r_cnt + DIV_LOG'(1);
      if (w_wr) r_wptr <= r_wptr + DEPTH_LOG'(1);
      if (w_pop) begin
        r_rptr   <= r_rptr + DEPTH_LOG'(1);
        r_sample <= r_mem[r_rptr];
      end
      r_valid <= w_pop;
      if (w_uf) r_underflow <= 1'b1;
`ifdef PACER_UNDERFLOW_ZERO_EN
      if (w_emit_zero) begin
        r_sample <= '0;
        r_valid  <= 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.data_in;
  end

  assign bus.ack_in       = r_ack;
  assign bus.sample_out   = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.underflow    = r_underflow;
  assign bus.level        = r_level;

endmodule
